cubehash_ctrl: RTL and testbench

CUBEHASH_CTRL -- requirements
Module: cubehash_ctrl

---
 rtl/cubehash_pkg.sv | 17 +
 rtl/cubehash_ctrl_if.sv | 24 ++
 rtl/cubehash_ctrl.sv | 104 ++++++++++
 tb/tb_cubehash_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cubehash_pkg.sv
// Shared types and default round counts for the CubeHash sequencing controller.
package cubehash_pkg;

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    ABSORB = 3'd2,
    FINAL  = 3'd3,
    OUT    = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam int ROUNDS_DEF     = 16;
  localparam int FIN_ROUNDS_DEF = 160;
  localparam int CNT_W          = 8;

endpackage

// File: rtl/cubehash_ctrl_if.sv
// Block handshake plus round-datapath control bundle for cubehash_ctrl.
interface cubehash_ctrl_if;
  logic         blk_valid;
  logic [255:0] blk_data;
  logic         blk_last;
  logic         blk_ready;
  logic [255:0] msg;
  logic         done;
  logic         start1;
  logic         in_en;
  logic         stop_process;
  logic         xor_fin;
  logic         out_en;

  modport master (
    output blk_valid, blk_data, blk_last,
    input  blk_ready, msg, done, start1, in_en, stop_process, xor_fin, out_en
  );

  modport slave (
    input  blk_valid, blk_data, blk_last,
    output blk_ready, msg, done, start1, in_en, stop_process, xor_fin, out_en
  );
endinterface

// File: rtl/cubehash_ctrl.sv
// Sequences block absorption, finalization and output for a CubeHash round datapath.
// Every cycle with stop_process=0 is one datapath round.
module cubehash_ctrl
  import cubehash_pkg::*;
#(
  parameter int ROUNDS     = ROUNDS_DEF,
  parameter int FIN_ROUNDS = FIN_ROUNDS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  cubehash_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ABS_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] FIN_LAST = CNT_W'(FIN_ROUNDS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             ready, stop, start1, xor_fin, out_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARM;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ready   = 1'b0;
    stop    = 1'b1;
    start1  = 1'b0;
    xor_fin = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      ARM: begin
        start1  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        start1 = 1'b1;
        ready  = 1'b1;
        stop   = ~bus.blk_valid;
        if (bus.blk_valid) begin
          last_d  = bus.blk_last;
          cnt_d   = '0;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        if (cnt_q != ABS_LAST) begin
          stop  = 1'b0;
          cnt_d = cnt_q + 1'b1;
        end else if (!last_q) begin
          // Last round of a non-final block: accept the next one or stall in place.
          ready = 1'b1;
          if (bus.blk_valid) begin
            stop   = 1'b0;
            last_d = bus.blk_last;
            cnt_d  = '0;
          end
        end else begin
          stop    = 1'b0;
          cnt_d   = '0;
          state_d = FINAL;
        end
      end
      FINAL: begin
        stop    = 1'b0;
        xor_fin = (cnt_q == '0);
        if (cnt_q == FIN_LAST) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        out_en  = 1'b1;
        state_d = HOLD;
      end
      HOLD: ;
      default: state_d = ARM;
    endcase
  end

  assign bus.blk_ready    = ready;
  assign bus.done         = bus.blk_valid & ready;
  assign bus.msg          = bus.blk_data;
  assign bus.start1       = start1;
  assign bus.in_en        = 1'b1;
  assign bus.stop_process = stop;
  assign bus.xor_fin      = xor_fin;
  assign bus.out_en       = out_en;

endmodule

// File: tb/tb_cubehash_ctrl.sv
// Directed self-checking bench for cubehash_ctrl with default ROUNDS=16, FIN_ROUNDS=160.
module tb_cubehash_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  cubehash_ctrl_if bus ();

  cubehash_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic valid;
    logic last;
    logic ready;
    logic done;
    logic stop;
    logic start1;
    logic xor_fin;
    logic out_en;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [255:0] d);
    bus.blk_valid = v;
    bus.blk_last  = l;
    bus.blk_data  = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bus.blk_ready),    0);
    chk({tag, "_done"},   32'(bus.done),         0);
    chk({tag, "_xor"},    32'(bus.xor_fin),      0);
    chk({tag, "_out"},    32'(bus.out_en),       0);
    chk({tag, "_stop"},   32'(bus.stop_process), 1);
    chk({tag, "_start1"}, 32'(bus.start1),       1);
    chk({tag, "_in_en"},  32'(bus.in_en),        1);
  endtask

  // Leaves the DUT in ARM, one posedge+1 after reset release.
  task automatic do_reset();
    drive(1'b1, 1'b1, 256'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ARM cycle then accept one block in IDLE; returns the done cycle.
  task automatic start_block(input logic last, input logic [255:0] d, output int done_c);
    drive(1'b0, 1'b0, 256'h0);
    tick();
    drive(1'b1, last, d);
    #1;
    chk("accept_done", 32'(bus.done), 1);
    chk("accept_start1", 32'(bus.start1), 1);
    done_c = cyc;
    tick();
    drive(1'b0, 1'b0, 256'h0);
  endtask

  task automatic wait_out(input int limit, output int out_c, output int xor_c);
    out_c = -1;
    xor_c = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.xor_fin && xor_c < 0) xor_c = cyc;
      if (bus.out_en) begin
        out_c = cyc;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int done0, done1, out_c, xor_c;
    logic [255:0] data;

    drive(1'b0, 1'b0, 256'h0);
    #3;

    // Two-block message: reset-release behavior, absorb rounds with blk_last ignored, second accept.
    vecs[0] = '{1, 1, 0, 0, 1, 1, 0, 0};
    vecs[1] = '{1, 0, 1, 1, 0, 1, 0, 0};
    for (int i = 2; i <= 16; i++) vecs[i] = '{1, 1, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 1, 1, 1, 0, 0, 0, 0};

    do_reset();
    done0 = 0;
    done1 = 0;
    for (int i = 0; i < 18; i++) begin
      data = {8{32'(i * 32'h01010101 + 32'h5a)}};
      drive(vecs[i].valid, vecs[i].last, data);
      #1;
      chk($sformatf("v%0d_ready", i),  32'(bus.blk_ready),    32'(vecs[i].ready));
      chk($sformatf("v%0d_done", i),   32'(bus.done),         32'(vecs[i].done));
      chk($sformatf("v%0d_stop", i),   32'(bus.stop_process), 32'(vecs[i].stop));
      chk($sformatf("v%0d_start1", i), 32'(bus.start1),       32'(vecs[i].start1));
      chk($sformatf("v%0d_xor", i),    32'(bus.xor_fin),      32'(vecs[i].xor_fin));
      chk($sformatf("v%0d_out", i),    32'(bus.out_en),       32'(vecs[i].out_en));
      chk($sformatf("v%0d_msg", i),    32'(bus.msg === data), 1);
      if (i == 1) done0 = cyc;
      if (i == 17) done1 = cyc;
      tick();
    end
    drive(1'b0, 1'b0, 256'h0);
    chk("two_blk_second_done", 32'(done1 - done0), 16);
    wait_out(400, out_c, xor_c);
    chk("two_blk_xor", 32'(xor_c - done0), 33);
    chk("two_blk_out", 32'(out_c - done0), 193);

    // Single final block 256'h80, then HOLD ignores further blocks.
    do_reset();
    start_block(1'b1, 256'h80, done0);
    wait_out(400, out_c, xor_c);
    chk("one_blk_xor", 32'(xor_c - done0), 17);
    chk("one_blk_out", 32'(out_c - done0), 177);
    chk("out_stop", 32'(bus.stop_process), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1'b1, 1'b1, 256'h80);
      #1;
      chk("hold_ready", 32'(bus.blk_ready), 0);
      chk("hold_done", 32'(bus.done), 0);
      chk("hold_stop", 32'(bus.stop_process), 1);
      chk("hold_out", 32'(bus.out_en), 0);
      chk("hold_start1", 32'(bus.start1), 0);
    end

    // Second block withheld 5 cycles at cnt=15, with blk_last toggling while not ready.
    do_reset();
    start_block(1'b0, 256'h1234, done0);
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, k[0], 256'h0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 256'h0);
      #1;
      chk("stall_stop", 32'(bus.stop_process), 1);
      chk("stall_ready", 32'(bus.blk_ready), 1);
      chk("stall_done", 32'(bus.done), 0);
      tick();
    end
    drive(1'b1, 1'b1, 256'h5678);
    #1;
    chk("stall_accept_done", 32'(bus.done), 1);
    chk("stall_accept_stop", 32'(bus.stop_process), 0);
    chk("stall_accept_cyc", 32'(cyc - done0), 21);
    tick();
    drive(1'b0, 1'b0, 256'h0);
    wait_out(400, out_c, xor_c);
    chk("stall_out", 32'(out_c - done0), 198);

    // Reset in the middle of finalization, then a fresh single-block message.
    do_reset();
    start_block(1'b1, 256'h80, done0);
    for (int k = 0; k < 96; k++) tick();
    #1;
    chk("mid_final_stop", 32'(bus.stop_process), 0);
    chk("mid_final_cyc", 32'(cyc - done0), 97);
    drive(1'b1, 1'b1, 256'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    tick();
    rst_n = 1'b1;
    start_block(1'b1, 256'h80, done1);
    wait_out(400, out_c, xor_c);
    chk("after_abort_out", 32'(out_c - done1), 177);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
